event_frame_writer: RTL

//  Write-side framer feeding the 16384x18 sample FIFO in the digitizer capture path.
//  On a trigger edge it writes one event frame into the FIFO:

---
 rtl/event_frame_writer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/event_frame_writer.sv
// Write-side framer for the capture sample FIFO: header, LENGTH samples, trailer per trigger,
// with FIFO back-pressure handling, truncation and saturating count of rejected triggers.
module event_frame_writer #(
    parameter int LEN_W  = 14,
    parameter int DROP_W = 16
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              ENABLE,
    input  logic              TRIG,
    input  logic [LEN_W-1:0]  LENGTH,
    input  logic [15:0]       SAMPLE,
    input  logic              SAMPLE_VLD,
    input  logic              FIFO_AFULL,
    input  logic              FIFO_FULL,
    output logic [17:0]       FIFO_DATA,
    output logic              FIFO_WE,
    output logic              BUSY,
    output logic [15:0]       EVENT_CNT,
    output logic [DROP_W-1:0] DROP_CNT
);

    // The trailer reports the sample count in a 15-bit field.
    if (LEN_W < 1 || LEN_W > 15) begin : g_len_w_check
        $error("event_frame_writer: LEN_W must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        TRAILER = 2'd2
    } state_t;

    localparam logic [1:0] TAG_HEADER  = 2'b01;
    localparam logic [1:0] TAG_SAMPLE  = 2'b00;
    localparam logic [1:0] TAG_TRAILER = 2'b11;

    state_t            state;
    logic              trig_d;
    logic              trunc;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  count;
    logic [LEN_W-1:0]  count_inc;
    logic [14:0]       n_written;
    logic              trig_edge;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [LEN_W-1:0] eff_length(input logic [LEN_W-1:0] l);
        return (l == '0) ? LEN_W'(1) : l;
    endfunction

    assign trig_edge = TRIG & ~trig_d;
    assign count_inc = count + 1'b1;
    assign n_written = 15'(count);
    assign BUSY      = (state != IDLE);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            trig_d    <= 1'b0;
            trunc     <= 1'b0;
            len_q     <= '0;
            count     <= '0;
            FIFO_WE   <= 1'b0;
            FIFO_DATA <= '0;
            EVENT_CNT <= '0;
            DROP_CNT  <= '0;
        end else begin
            trig_d  <= TRIG;
            FIFO_WE <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (trig_edge) begin
                        if (ENABLE && !FIFO_AFULL) begin
                            FIFO_WE   <= 1'b1;
                            FIFO_DATA <= {TAG_HEADER, EVENT_CNT};
                            state     <= CAPTURE;
                            count     <= '0;
                            trunc     <= 1'b0;
                            len_q     <= eff_length(LENGTH);
                        end else begin
                            DROP_CNT <= sat_inc(DROP_CNT);
                        end
                    end
                end

                CAPTURE: begin
                    if (trig_edge) DROP_CNT <= sat_inc(DROP_CNT);
                    // FULL is folded in so a write is never issued against a full FIFO.
                    if (FIFO_AFULL || FIFO_FULL) begin
                        trunc <= 1'b1;
                        state <= TRAILER;
                    end else if (SAMPLE_VLD) begin
                        FIFO_WE   <= 1'b1;
                        FIFO_DATA <= {TAG_SAMPLE, SAMPLE};
                        count     <= count_inc;
                        if (count_inc == len_q) state <= TRAILER;
                    end
                end

                TRAILER: begin
                    if (trig_edge) DROP_CNT <= sat_inc(DROP_CNT);
                    if (!FIFO_FULL) begin
                        FIFO_WE   <= 1'b1;
                        FIFO_DATA <= {TAG_TRAILER, trunc, n_written};
                        EVENT_CNT <= EVENT_CNT + 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
